// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: active-low segment
// patterns ({g,f,e,d,c,b,a}) and default scan timing.
package seg7_pkg;

  localparam int SCAN_DIV_DEF  = 50000;
  localparam int BLANK_CYC_DEF = 500;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low seven-segment pattern.
// Hex A-F are decoded so that invalid BCD is visible on the display.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode seven-segment driver: per-frame input snapshot,
// ghosting gap at the start of every digit slot, optional leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [4*N_DIG-1:0] digits,
  input  logic [N_DIG-1:0]   dig_en,
  input  logic [N_DIG-1:0]   dp,
  input  logic               lz_blank,
  output logic [N_DIG-1:0]   an,
  output logic [6:0]         seg,
  output logic               dp_n,
  output logic               frame_tick
);

  if (N_DIG < 2 || N_DIG > 8) begin : g_bad_ndig
    $error("seg7_scan: N_DIG must be in 2..8");
  end
  if (BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
    $error("seg7_scan: need 1 <= BLANK_CYC < SCAN_DIV");
  end

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIG);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIG - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4*N_DIG-1:0] snap_dig_q;
  logic [N_DIG-1:0]   snap_en_q, snap_dp_q;
  logic               snap_lz_q;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_n_q, dp_n_d;
  logic               tick_q;

  logic               frame_start;
  logic [N_DIG-1:0]   blank;
  logic [3:0]         cur_code;
  logic [6:0]         cur_seg;

  always_comb begin
    frame_start = (cnt_q == '0) && (idx_q == '0);
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Walk down from the top digit; a digit is blanked while everything at or
  // above it is still zero. Digit 0 always stays visible.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      upper_zero = upper_zero & (snap_dig_q[4*k +: 4] == 4'd0);
      blank[k]   = snap_lz_q & upper_zero & (k != 0);
    end
  end

  assign cur_code = snap_dig_q[4*int'(idx_q) +: 4];

  seg7_decode u_decode (
    .code_i (cur_code),
    .seg_o  (cur_seg)
  );

  always_comb begin
    an_d   = '1;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    if (cnt_q >= CNT_BLANK && snap_en_q[idx_q] && !blank[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = cur_seg;
      dp_n_d      = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_dig_q <= '0;
      snap_en_q  <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      dp_n_q     <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
      tick_q <= frame_start;
      if (frame_start) begin
        snap_dig_q <= digits;
        snap_en_q  <= dig_en;
        snap_dp_q  <= dp;
        snap_lz_q  <= lz_blank;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: per-edge expected outputs from a frame/slot model are
// queued by the driver and consumed by an independent output monitor.
module tb_seg7_scan;

  localparam int N_DIG     = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = N_DIG * SCAN_DIV;
  localparam int W         = N_DIG + 7 + 1 + 1;

  logic               clk      = 1'b0;
  logic               clr_n    = 1'b0;
  logic [4*N_DIG-1:0] digits   = '0;
  logic [N_DIG-1:0]   dig_en   = '0;
  logic [N_DIG-1:0]   dp       = '0;
  logic               lz_blank = 1'b0;
  logic [N_DIG-1:0]   an;
  logic [6:0]         seg;
  logic               dp_n;
  logic               frame_tick;

  seg7_scan #(
    .N_DIG     (N_DIG),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .digits     (digits),
    .dig_en     (dig_en),
    .dp         (dp),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  // clock / reset timing
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           exp_e_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           e_cnt    = 0;

  // reference model state: what the display latched at the last frame start
  logic [4*N_DIG-1:0] m_dig;
  logic [N_DIG-1:0]   m_en, m_dp;
  logic               m_lz;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Expected pins after edge e (edge 0 = first edge after reset release).
  function automatic logic [W-1:0] model_out(input int e);
    int                 pos, slot, c;
    logic [4*N_DIG-1:0] upper;
    logic [N_DIG-1:0]   a;
    logic [6:0]         s;
    logic               d, lit;
    pos   = e % FRAME;
    slot  = pos / SCAN_DIV;
    c     = pos % SCAN_DIV;
    upper = m_dig >> (4 * slot);
    lit   = (c >= BLANK_CYC) && m_en[slot] && !(m_lz && slot != 0 && upper == 0);
    a = '1;
    s = 7'h7F;
    d = 1'b1;
    if (lit) begin
      a = ~(N_DIG'(1) << slot);
      s = dec_tab[upper[3:0]];
      d = ~m_dp[slot];
    end
    return {a, s, d, (pos == 0)};
  endfunction

  // driver: inputs are stable from this negedge through the next posedge
  task automatic step();
    if (e_cnt % FRAME == 0) begin
      m_dig = digits;
      m_en  = dig_en;
      m_dp  = dp;
      m_lz  = lz_blank;
    end
    exp_q.push_back(model_out(e_cnt));
    exp_e_q.push_back(e_cnt);
    e_cnt++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v, got;
      int           e;
      exp_v = exp_q.pop_front();
      e     = exp_e_q.pop_front();
      got   = {an, seg, dp_n, frame_tick};
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL out e=%0d: got an=%b seg=%h dp_n=%b tick=%b, expected an=%b seg=%h dp_n=%b tick=%b",
                 e, an, seg, dp_n, frame_tick,
                 exp_v[W-1 -: N_DIG], exp_v[8:2], exp_v[1], exp_v[0]);
      end
      check("one_anode", 32'($countones(~an) <= 1), 32'd1);
      if (an == '1) check("dark_seg", 32'(seg), 32'h7F);
    end
  end

  initial begin
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp_n", 32'(dp_n), 32'd1);
    check("rst_tick", 32'(frame_tick), 32'd0);

    // scan pattern, then asynchronous reset in the middle of lit slot 0
    digits = 16'h1234; dig_en = 4'hF; dp = 4'b0010; lz_blank = 1'b0;
    clr_n = 1'b1; e_cnt = 0;
    run(5);
    #2;
    check("pre_rst_an", 32'(an), 32'hE);
    clr_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_dp_n", 32'(dp_n), 32'd1);
    check("async_rst_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1; e_cnt = 0;
    run(2 * FRAME);

    // leading-zero blanking
    digits = 16'h0050; dp = '0; lz_blank = 1'b1;
    run(FRAME);
    digits = 16'h0000;
    run(FRAME);

    // anti-tearing: change arrives during slot 1
    digits = 16'h1234; lz_blank = 1'b0;
    run(FRAME + SCAN_DIV + 3);
    digits = 16'h9876;
    run(FRAME - SCAN_DIV - 3);
    run(FRAME);

    // per-digit enable and hex codes
    dig_en = 4'b0101; digits = 16'hFEA0;
    run(FRAME);
    dig_en = 4'hF; digits = 16'h00A0;
    run(FRAME);

    // random traffic with changes landing anywhere in the frame
    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        digits   = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dig_en   = 4'($urandom);
        dp       = 4'($urandom);
        lz_blank = 1'($urandom_range(0, 1));
      end
      step();
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
